// File: rtl/cpu_pkg.sv
// Shared constants, state encodings and width helpers for the arbitration slice.
package cpu_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_CHANNELS = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   typedef enum logic {
      ARB_RR     = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_mode_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // A single-bit index is still needed when clog2 collapses to zero.
   function automatic int sel_width(input int channels);
      return (clog2(channels) < 1) ? 1 : clog2(channels);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: the first requester after last_grant, wrapping modulo CHANNELS.
module rr_arbiter
   import cpu_pkg::*;
#(
   parameter int  CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = sel_width(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    last_grant,
   output logic [CHANNELS-1:0] grant_onehot,
   output logic [SEL_W-1:0]    grant_idx,
   output logic                any
);

   // Each channel gets a priority distance from last_grant; the smallest requesting one wins.
   always_comb begin
      int best;
      best      = CHANNELS;
      grant_idx = '0;
      for (int j = 0; j < CHANNELS; j++) begin
         int d;
         d = j + CHANNELS - 1 - int'(last_grant);
         if (d >= CHANNELS) d = d - CHANNELS;
         if (req[j] && (d < best)) begin
            best      = d;
            grant_idx = SEL_W'(j);
         end
      end
      any = (best < CHANNELS);
   end

   always_comb begin
      grant_onehot = '0;
      for (int j = 0; j < CHANNELS; j++) begin
         grant_onehot[j] = any && (grant_idx == SEL_W'(j));
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 stream mux with a single registered output stage.
// Optional packet locking is enabled by defining RR_ARB_MUX_LOCK_EN.
module rr_arb_mux
   import cpu_pkg::*;
#(
   parameter int  WIDTH    = DEF_WIDTH,
   parameter int  CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_last,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan
);

   out_state_t          out_state;
   logic [SEL_W-1:0]    last_grant;
   logic [CHANNELS-1:0] req;
   logic [CHANNELS-1:0] grant_onehot;
   logic [SEL_W-1:0]    grant_idx;
   logic                grant_any;
   logic                load;
   logic                transfer;
   logic [WIDTH-1:0]    sel_data;

`ifdef RR_ARB_MUX_LOCK_EN
   arb_mode_t           arb_mode;
   logic [CHANNELS-1:0] lock_mask;
   logic                grant_last;

   always_comb begin
      for (int j = 0; j < CHANNELS; j++) begin
         lock_mask[j] = (last_grant == SEL_W'(j));
      end
   end

   // While locked only the owning channel may compete.
   assign req        = (arb_mode == ARB_LOCKED) ? (in_valid & lock_mask) : in_valid;
   assign grant_last = |(in_last & grant_onehot);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_mode <= ARB_RR;
      end else if (transfer) begin
         arb_mode <= grant_last ? ARB_RR : ARB_LOCKED;
      end
   end
`else
   logic unused_last;

   assign req         = in_valid;
   assign unused_last = ^in_last;
`endif

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_arbiter (
      .req          (req),
      .last_grant   (last_grant),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any          (grant_any)
   );

   // Ready is gated by rst_n so no channel sees an accept while reset is asserted.
   assign load      = (out_state == ST_EMPTY) || out_ready;
   assign in_ready  = grant_onehot & {CHANNELS{load & rst_n}};
   assign transfer  = grant_any & load & rst_n;
   assign out_valid = (out_state == ST_FULL);

   always_comb begin
      sel_data = '0;
      for (int j = 0; j < CHANNELS; j++) begin
         if (grant_onehot[j]) sel_data = sel_data | in_data[j*WIDTH +: WIDTH];
      end
   end

   // Output stage: capture on transfer, drain to EMPTY when consumed with nothing new.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_state  <= ST_EMPTY;
         out_data   <= '0;
         out_chan   <= '0;
         last_grant <= SEL_W'(CHANNELS - 1);
      end else if (transfer) begin
         out_state  <= ST_FULL;
         out_data   <= sel_data;
         out_chan   <= grant_idx;
         last_grant <= grant_idx;
      end else if (out_ready) begin
         out_state  <= ST_EMPTY;
      end
   end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of every channel in bits (1..64).
REQ-002 SHALL have parameter CHANNELS, default 4, the number of input channels (2..32).
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(CHANNELS)), the width of the channel index.
REQ-004 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have in_valid  input  CHANNELS  per-channel request; bit i belongs to channel i.
REQ-007 SHALL have in_data  input  CHANNELS*WIDTH  flattened data; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have in_last  input  CHANNELS  per-channel end-of-packet flag; used only when the REQ-025 macro is defined.
REQ-009 SHALL have in_ready  output  CHANNELS  per-channel accept; a transfer on channel i occurs when in_valid[i] and in_ready[i] are both high at a rising edge.
REQ-010 SHALL have out_valid  output  1  the output register holds a word.
REQ-011 SHALL have out_ready  input  1  the downstream accepts the word.
REQ-012 SHALL have out_data  output  WIDTH  the registered winning word.
REQ-013 SHALL have out_chan  output  SEL_W  the index of the channel that sourced out_data.

Function
REQ-014 SHALL hold one output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL define load = (state EMPTY) or out_ready, i.e. the register can take a new word in this cycle.
REQ-016 SHALL grant round-robin: search begins at last_grant+1, wraps modulo CHANNELS, and selects the first channel with in_valid high.
REQ-017 SHALL drive in_ready[g] = load for the granted channel g and 0 for every other channel; at most one in_ready bit is high per cycle.
REQ-018 SHALL, on a transfer, capture in_data of g into out_data and g into out_chan, set out_valid, and update last_grant to g; latency from accepted input to out_valid is exactly 1 cycle.
REQ-019 SHALL, when FULL and out_ready is high with no input valid, go EMPTY with out_data and out_chan unchanged.
REQ-020 SHALL, when FULL and out_ready is high with an input valid, sustain one word per cycle (accept and drain in the same cycle).
REQ-021 SHALL, when FULL and out_ready is low, hold out_valid, out_data and out_chan stable and drive all in_ready low.
REQ-022 SHALL leave last_grant unchanged in any cycle with no transfer; grant is combinational from in_valid and last_grant.
REQ-023 SHALL behave for non-power-of-two CHANNELS: wrap from CHANNELS-1 to 0, never granting an index >= CHANNELS.

Reset
REQ-024 SHALL, while rst_n is low, force state EMPTY, out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1 (so channel 0 has first priority), all in_ready low; a word held mid-operation is discarded.

Configuration
REQ-025 SHALL, when macro RR_ARB_MUX_LOCK_EN is defined, add state LOCKED: after a transfer from g with in_last[g]=0, the grant stays on g (other channels ignored) until a transfer from g with in_last[g]=1, which returns to round-robin.
REQ-026 SHALL, without RR_ARB_MUX_LOCK_EN, ignore in_last and re-arbitrate after every transfer; reset clears any lock.

Structure
REQ-027 SHALL take clog2 helper and the default WIDTH/CHANNELS constants from the shared package cpu_pkg.
REQ-028 SHALL implement the round-robin search in one sub-module rr_arbiter (inputs req, last_grant; outputs grant_onehot, grant_idx, any); datapath and register stay in rr_arb_mux.

Verification
REQ-029 SHALL cover: after reset, in_valid=4'b1111, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-030 SHALL cover: in_valid=4'b0100, data 0xDEADBEEF on ch2, out_ready=0 for 3 cycles -> out_valid=1, out_data=0xDEADBEEF, out_chan=2 stable, in_ready=0 throughout.
REQ-031 SHALL cover: CHANNELS=3, last_grant=2, in_valid=3'b011 -> grant channel 0, then channel 1.
REQ-032 SHALL cover: rst_n driven low mid-stream while FULL -> out_valid=0 asynchronously, next grant is channel 0.
REQ-033 SHALL cover (RR_ARB_MUX_LOCK_EN): ch1 sends 3 beats, in_last on the 3rd, ch0 valid throughout -> out_chan 1,1,1,0; without the macro -> 1,0,1,0.
